uart_rx_frame_checker: RTL and testbench

Parametrised UART receive frame checker. It sits between the RX oversampler/bit-sampler and the RX data buffer. From mid-bit samples it assembles the data word LSB-first and checks parity in four modes, or none, and one or two stop bits. Per frame it reports a parity flag and a framing flag, and it also keeps sticky flags and saturating error counters.

---
 rtl/uart_rx_pkg.sv | 35 +++
 rtl/uart_rx_sat_counter.sv | 38 +++
 rtl/uart_rx_frame_checker.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_rx_frame_checker.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
// Types and constants shared by the UART receive frame checker:
//   - par_mode encodings for the parity bit
//   - FSM state encoding
//   - expected_parity(): the parity bit the line should carry for a given
//     mode and running XOR of the data bits
package uart_rx_pkg;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP1  = 3'd3,
    ST_STOP2  = 3'd4
  } rx_state_t;

  // Expected parity bit for the frame; run_par is the XOR of all data bits
  function automatic logic expected_parity(input logic [1:0] mode, input logic run_par);
    logic exp_bit;
    case (mode)
      PAR_EVEN:  exp_bit = run_par;
      PAR_ODD:   exp_bit = ~run_par;
      PAR_MARK:  exp_bit = 1'b1;
      PAR_SPACE: exp_bit = 1'b0;
      default:   exp_bit = 1'b0;
    endcase
    return exp_bit;
  endfunction

endpackage

// File: rtl/uart_rx_sat_counter.sv
// uart_rx_sat_counter
// Saturating up-counter used for the receive error statistics.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   inc         add one this cycle (ignored once the counter is full)
//   clr         clear to zero; wins over inc
//   count       current value, registered
module uart_rx_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_r;

  // Counter register: clear has priority, increment stops at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/uart_rx_frame_checker.sv
// uart_rx_frame_checker
// Assembles a UART data word from mid-bit samples (LSB first), checks the
// optional parity bit (even/odd/mark/space) and one or two stop bits, and
// reports per-frame flags plus sticky flags and saturating error counters.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   par_en, par_mode, stop2    frame format, latched at frame_start
//   frame_start                start bit confirmed by the sampler
//   bit_valid, bit_in          one strobe per mid-bit sample after the start bit
//   err_clr                    clears sticky flags and counters (wins over updates)
//   rx_data, rx_valid          received word and its one-cycle completion pulse
//   parity_error, framing_error  flags of the last completed frame
//   par_err_sticky, frm_err_sticky, par_err_cnt, frm_err_cnt  error history
//   busy                       FSM is inside a frame
module uart_rx_frame_checker
  import uart_rx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              par_en,
  input  logic [1:0]        par_mode,
  input  logic              stop2,
  input  logic              frame_start,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              err_clr,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_error,
  output logic              framing_error,
  output logic              par_err_sticky,
  output logic              frm_err_sticky,
  output logic [CNT_W-1:0]  par_err_cnt,
  output logic [CNT_W-1:0]  frm_err_cnt,
  output logic              busy
);

  // Bit counter is 4 bits wide, enough for DATA_W up to 9
  localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

  rx_state_t         state_r, next_state_s;
  logic              frame_done_s;
  logic              par_hit_s, frm_hit_s;
  logic              par_flag_s, frm_flag_s;

  logic [3:0]        bit_cnt_r;
  logic [DATA_W-1:0] shift_r;
  logic              run_par_r;
  logic              par_en_r, stop2_r;
  logic [1:0]        par_mode_r;
  logic              par_flag_r, frm_flag_r;

  logic [DATA_W-1:0] rx_data_r;
  logic              rx_valid_r, parity_error_r, framing_error_r;
  logic              par_sticky_r, frm_sticky_r, busy_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode, frame completion and per-frame flag evaluation
  always_comb begin
    next_state_s = state_r;
    frame_done_s = 1'b0;
    par_hit_s    = 1'b0;
    frm_hit_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (frame_start) begin
          next_state_s = ST_DATA;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (bit_valid && (bit_cnt_r == LAST_BIT)) begin
          if (par_en_r) begin
            next_state_s = ST_PARITY;
          end else begin
            next_state_s = ST_STOP1;
          end
        end else begin
          next_state_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_valid) begin
          par_hit_s    = (bit_in != expected_parity(par_mode_r, run_par_r));
          next_state_s = ST_STOP1;
        end else begin
          next_state_s = ST_PARITY;
        end
      end
      ST_STOP1: begin
        if (bit_valid) begin
          frm_hit_s = ~bit_in;
          if (stop2_r) begin
            next_state_s = ST_STOP2;
          end else begin
            next_state_s = ST_IDLE;
            frame_done_s = 1'b1;
          end
        end else begin
          next_state_s = ST_STOP1;
        end
      end
      ST_STOP2: begin
        if (bit_valid) begin
          frm_hit_s    = ~bit_in;
          next_state_s = ST_IDLE;
          frame_done_s = 1'b1;
        end else begin
          next_state_s = ST_STOP2;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
    // Flags include the sample being taken this cycle so completion sees it
    par_flag_s = (par_flag_r | par_hit_s) & par_en_r;
    frm_flag_s = frm_flag_r | frm_hit_s;
  end

  // Frame datapath, shadow format registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r       <= 4'd0;
      shift_r         <= '0;
      run_par_r       <= 1'b0;
      par_en_r        <= 1'b0;
      par_mode_r      <= 2'b00;
      stop2_r         <= 1'b0;
      par_flag_r      <= 1'b0;
      frm_flag_r      <= 1'b0;
      rx_data_r       <= '0;
      rx_valid_r      <= 1'b0;
      parity_error_r  <= 1'b0;
      framing_error_r <= 1'b0;
      par_sticky_r    <= 1'b0;
      frm_sticky_r    <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      rx_valid_r <= frame_done_s;
      busy_r     <= (next_state_s != ST_IDLE);

      if ((state_r == ST_IDLE) && frame_start) begin
        par_en_r   <= par_en;
        par_mode_r <= par_mode;
        stop2_r    <= stop2;
        bit_cnt_r  <= 4'd0;
        run_par_r  <= 1'b0;
        par_flag_r <= 1'b0;
        frm_flag_r <= 1'b0;
      end else begin
        if ((state_r == ST_DATA) && bit_valid) begin
          // Right shift with new bit at MSB leaves the first bit in the LSB
          shift_r   <= {bit_in, shift_r[DATA_W-1:1]};
          run_par_r <= run_par_r ^ bit_in;
          bit_cnt_r <= bit_cnt_r + 4'd1;
        end else begin
          shift_r   <= shift_r;
          run_par_r <= run_par_r;
          bit_cnt_r <= bit_cnt_r;
        end
        par_flag_r <= par_flag_s;
        frm_flag_r <= frm_flag_s;
      end

      if (frame_done_s) begin
        rx_data_r       <= shift_r;
        parity_error_r  <= par_flag_s;
        framing_error_r <= frm_flag_s;
      end else begin
        rx_data_r       <= rx_data_r;
        parity_error_r  <= parity_error_r;
        framing_error_r <= framing_error_r;
      end

      if (err_clr) begin
        par_sticky_r <= 1'b0;
        frm_sticky_r <= 1'b0;
      end else if (frame_done_s) begin
        par_sticky_r <= par_sticky_r | par_flag_s;
        frm_sticky_r <= frm_sticky_r | frm_flag_s;
      end else begin
        par_sticky_r <= par_sticky_r;
        frm_sticky_r <= frm_sticky_r;
      end
    end
  end

  uart_rx_sat_counter #(.CNT_W(CNT_W)) u_par_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (frame_done_s & par_flag_s),
    .clr   (err_clr),
    .count (par_err_cnt)
  );

  uart_rx_sat_counter #(.CNT_W(CNT_W)) u_frm_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (frame_done_s & frm_flag_s),
    .clr   (err_clr),
    .count (frm_err_cnt)
  );

  assign rx_data        = rx_data_r;
  assign rx_valid       = rx_valid_r;
  assign parity_error   = parity_error_r;
  assign framing_error  = framing_error_r;
  assign par_err_sticky = par_sticky_r;
  assign frm_err_sticky = frm_sticky_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// tb_uart_rx_frame_checker
// Directed bench: two instances, u_dut8 (DATA_W=8, CNT_W=2) and
// u_dut7 (DATA_W=7, CNT_W=8), each with its own frame_start/bit_valid;
// all other inputs are shared. Expected values are hand-computed.
module tb_uart_rx_frame_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic par_en, stop2, bit_in, err_clr;
  logic [1:0] par_mode;
  logic [1:0] fs, bv;

  logic [7:0] rx_data8;
  logic rv8, pe8, fe8, ps8, fsk8, busy8;
  logic [1:0] pc8, fc8;

  logic [6:0] rx_data7;
  logic rv7, pe7, fe7, ps7, fsk7, busy7;
  logic [7:0] pc7, fc7;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  logic early_valid;
  logic busy_at_start;

  always #5 clk = ~clk;

  uart_rx_frame_checker #(.DATA_W(8), .CNT_W(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .par_en(par_en), .par_mode(par_mode), .stop2(stop2),
    .frame_start(fs[0]), .bit_valid(bv[0]), .bit_in(bit_in), .err_clr(err_clr),
    .rx_data(rx_data8), .rx_valid(rv8), .parity_error(pe8), .framing_error(fe8),
    .par_err_sticky(ps8), .frm_err_sticky(fsk8), .par_err_cnt(pc8), .frm_err_cnt(fc8),
    .busy(busy8)
  );

  uart_rx_frame_checker #(.DATA_W(7), .CNT_W(8)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .par_en(par_en), .par_mode(par_mode), .stop2(stop2),
    .frame_start(fs[1]), .bit_valid(bv[1]), .bit_in(bit_in), .err_clr(err_clr),
    .rx_data(rx_data7), .rx_valid(rv7), .parity_error(pe7), .framing_error(fe7),
    .par_err_sticky(ps7), .frm_err_sticky(fsk7), .par_err_cnt(pc7), .frm_err_cnt(fc7),
    .busy(busy7)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs read there too
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic valid_of(input int sel);
    return (sel == 0) ? rv8 : rv7;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy8 : busy7;
  endfunction

  // Sends one frame with idle gaps between samples. A stray bit_valid in
  // IDLE precedes it and a stray frame_start rides on the 4th sample; both
  // must be ignored. On return the completion edge has just passed.
  task automatic send_frame(input int sel, input logic [8:0] data, input int nbits,
                            input logic has_par, input logic par_bit, input logic s1,
                            input logic has_s2, input logic s2, input logic clr_last);
    logic [11:0] bits;
    int n;
    bits = 12'd0;
    n = 0;
    for (int i = 0; i < nbits; i++) begin
      bits[n] = data[i];
      n++;
    end
    if (has_par) begin
      bits[n] = par_bit;
      n++;
    end
    bits[n] = s1;
    n++;
    if (has_s2) begin
      bits[n] = s2;
      n++;
    end
    early_valid = 1'b0;
    bit_in = 1'b1; bv[sel] = 1'b1; cycle(); bv[sel] = 1'b0;
    fs[sel] = 1'b1; cycle(); fs[sel] = 1'b0;
    busy_at_start = busy_of(sel);
    for (int i = 0; i < n; i++) begin
      bit_in = bits[i];
      bv[sel] = 1'b1;
      if (i == 3) fs[sel] = 1'b1;
      if (i == n - 1) err_clr = clr_last;
      cycle();
      bv[sel] = 1'b0; fs[sel] = 1'b0; err_clr = 1'b0;
      if (i != n - 1) begin
        if (valid_of(sel)) early_valid = 1'b1;
        cycle();
        if (valid_of(sel)) early_valid = 1'b1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; par_en = 1'b0; par_mode = 2'b00; stop2 = 1'b0;
    bit_in = 1'b1; err_clr = 1'b0; fs = 2'b00; bv = 2'b00;
    #2;
    check("reset_rx_valid", rv8, 0);
    check("reset_rx_data", rx_data8, 0);
    check("reset_busy", busy8, 0);
    check("reset_par_cnt", pc8, 0);
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();

    // T1: even parity, 1 stop, 0xA5, parity bit 0; format change after start must not matter
    par_en = 1'b1; par_mode = 2'b00; stop2 = 1'b0;
    fork
      begin
        send_frame(0, 9'h0A5, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      begin
        @(posedge clk); @(posedge clk); #2;
        par_mode = 2'b01; par_en = 1'b0; stop2 = 1'b1;
      end
    join
    check("t1_busy_after_start", busy_at_start, 1);
    check("t1_no_early_valid", early_valid, 0);
    check("t1_rx_valid", rv8, 1);
    check("t1_rx_data", rx_data8, 8'hA5);
    check("t1_parity_error", pe8, 0);
    check("t1_framing_error", fe8, 0);
    check("t1_busy_falls", busy8, 0);
    check("t1_par_cnt", pc8, 0);
    check("t1_frm_cnt", fc8, 0);
    cycle();
    check("t1_valid_one_cycle", rv8, 0);
    check("t1_data_held", rx_data8, 8'hA5);

    // T2: odd parity, 0x03, parity bit 0 (expected 1)
    par_en = 1'b1; par_mode = 2'b01; stop2 = 1'b0;
    send_frame(0, 9'h003, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t2_rx_data", rx_data8, 8'h03);
    check("t2_parity_error", pe8, 1);
    check("t2_par_sticky", ps8, 1);
    check("t2_par_cnt", pc8, 1);
    check("t2_framing_error", fe8, 0);

    // T3: no parity, two stops, 0x5A, STOP1 = 0, STOP2 = 1
    par_en = 1'b0; par_mode = 2'b01; stop2 = 1'b1;
    send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t3_no_valid_before_stop2", early_valid, 0);
    check("t3_rx_valid", rv8, 1);
    check("t3_rx_data", rx_data8, 8'h5A);
    check("t3_framing_error", fe8, 1);
    check("t3_frm_cnt", fc8, 1);
    check("t3_frm_sticky", fsk8, 1);
    check("t3_parity_forced_0", pe8, 0);
    check("t3_par_cnt_kept", pc8, 1);
    cycle();

    // T4: DATA_W = 7, mark then space parity with parity bit 0
    par_en = 1'b1; par_mode = 2'b10; stop2 = 1'b0;
    send_frame(1, 9'h055, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t4_mark_rx_valid", rv7, 1);
    check("t4_mark_rx_data", rx_data7, 7'h55);
    check("t4_mark_parity_error", pe7, 1);
    cycle();
    par_mode = 2'b11;
    send_frame(1, 9'h02A, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t4_space_rx_data", rx_data7, 7'h2A);
    check("t4_space_parity_error", pe7, 0);
    check("t4_par_cnt7", pc7, 1);
    check("t4_dut8_idle", rv8, 0);
    cycle();

    // T5: CNT_W = 2 saturation and err_clr priority
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    check("t5_clr_par_cnt", pc8, 0);
    check("t5_clr_frm_cnt", fc8, 0);
    check("t5_clr_par_sticky", ps8, 0);
    check("t5_clr_frm_sticky", fsk8, 0);
    par_en = 1'b1; par_mode = 2'b01; stop2 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send_frame(0, 9'h003, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("t5_sat_cnt_%0d", k), pc8, (k < 3) ? k : 3);
      cycle();
    end
    send_frame(0, 9'h003, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t5_clr_wins_valid", rv8, 1);
    check("t5_clr_wins_cnt", pc8, 0);
    check("t5_clr_wins_sticky", ps8, 0);
    check("t5_clr_wins_parity_error", pe8, 1);
    cycle();

    // T6: reset after 4 data bits aborts the frame
    par_en = 1'b1; par_mode = 2'b00; stop2 = 1'b0;
    fs[0] = 1'b1; cycle(); fs[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_in = i[0]; bv[0] = 1'b1; cycle(); bv[0] = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_rx_valid", rv8, 0);
    check("t6_rst_rx_data", rx_data8, 0);
    check("t6_rst_parity_error", pe8, 0);
    check("t6_rst_busy", busy8, 0);
    check("t6_rst_rx_data7", rx_data7, 0);
    check("t6_rst_par_cnt7", pc7, 0);
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();
    check("t6_no_valid_after_abort", rv8, 0);
    send_frame(0, 9'h081, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t6_rx_valid", rv8, 1);
    check("t6_rx_data", rx_data8, 8'h81);
    check("t6_parity_error", pe8, 0);
    check("t6_framing_error", fe8, 0);
    cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
